// File: rtl/frame_buffer_pkg.sv
// Shared command opcodes and capture-state encoding for the frame buffer controller.
package frame_buffer_pkg;

  localparam logic [7:0] OP_ARM    = 8'h20;
  localparam logic [7:0] OP_AVAIL  = 8'h21;
  localparam logic [7:0] OP_READ   = 8'h22;
  localparam logic [7:0] OP_STATUS = 8'h24;
  localparam logic [7:0] OP_ABORT  = 8'h25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURING,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, plus single-cycle rise/fall pulses.
module sync_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic async_level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_level;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/frame_buffer_controller.sv
// Captures a framed stream of pixel words into an external RAM and serves the
// stored bytes, byte counts and status back over a byte-wide command interface.
module frame_buffer_controller
  import frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 14,
  parameter int COUNT_BYTES = 3
) (
  input  logic                  clock_spi_in,
  input  logic                  reset_sync_n,
  input  logic [7:0]            op_code_in,
  input  logic                  op_code_valid_in,
  input  logic [7:0]            operand_in,
  input  logic                  operand_valid_in,
  input  logic [31:0]           operand_count_in,
  output logic [7:0]            response_out,
  output logic                  response_valid_out,
  input  logic [DATA_WIDTH-1:0] pixel_word_in,
  input  logic                  pixel_word_valid_in,
  input  logic                  frame_valid_in,
  output logic                  buffer_write_enable_out,
  output logic [ADDR_WIDTH-1:0] buffer_write_address_out,
  output logic [DATA_WIDTH-1:0] buffer_write_data_out,
  output logic [ADDR_WIDTH-1:0] buffer_read_address_out,
  input  logic [DATA_WIDTH-1:0] buffer_read_data_in,
  output logic                  capture_active_out
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int CW         = ADDR_WIDTH + BYTE_SHIFT + 1;
  localparam int AW         = 8 * COUNT_BYTES;
  localparam logic [CW-1:0] DEPTH_WORDS = CW'({1'b1, {ADDR_WIDTH{1'b0}}});
  localparam logic [CW-1:0] BYTE_MASK   = CW'(BYTES - 1);

  state_t state, next_state;
  logic [CW-1:0] words_written, bytes_read, bytes_written, avail, read_ptr;
  logic [AW-1:0] snapshot, avail_ext;
  logic overflow, operand_prev, frame_rise, frame_fall;
  logic capturing, accept_word, arming, read_edge;
  logic cmd_arm, cmd_avail, cmd_read, cmd_status, cmd_abort;
  logic [7:0] avail_byte, read_byte, response_next;
  logic unused_operand;

  assign unused_operand = ^operand_in;

  sync_edge_detect frame_sync (
    .clock       (clock_spi_in),
    .reset_n     (reset_sync_n),
    .async_level (frame_valid_in),
    .rise        (frame_rise),
    .fall        (frame_fall)
  );

  assign cmd_arm    = op_code_valid_in && (op_code_in == OP_ARM);
  assign cmd_avail  = op_code_valid_in && (op_code_in == OP_AVAIL);
  assign cmd_read   = op_code_valid_in && (op_code_in == OP_READ);
  assign cmd_status = op_code_valid_in && (op_code_in == OP_STATUS);
  assign cmd_abort  = op_code_valid_in && (op_code_in == OP_ABORT);

  always_ff @(posedge clock_spi_in or negedge reset_sync_n) begin
    if (!reset_sync_n) state <= ST_IDLE;
    else               state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (cmd_abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (cmd_arm)    next_state = ST_ARMED;
        ST_ARMED:         if (frame_rise) next_state = ST_CAPTURING;
        ST_CAPTURING:     if (frame_fall) next_state = ST_DONE;
        default:          next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    capturing   = (state == ST_CAPTURING);
    accept_word = capturing && pixel_word_valid_in && !cmd_abort;
    arming      = cmd_arm && ((state == ST_IDLE) || (state == ST_DONE));
  end

  assign capture_active_out = capturing;

  // Once the buffer is full, words are dropped and the count saturates at DEPTH.
  always_ff @(posedge clock_spi_in or negedge reset_sync_n) begin
    if (!reset_sync_n) begin
      words_written            <= '0;
      overflow                 <= 1'b0;
      buffer_write_enable_out  <= 1'b0;
      buffer_write_address_out <= '0;
      buffer_write_data_out    <= '0;
    end else begin
      buffer_write_enable_out <= 1'b0;
      if (arming) begin
        words_written <= '0;
        overflow      <= 1'b0;
      end else if (accept_word) begin
        if (words_written == DEPTH_WORDS) begin
          overflow <= 1'b1;
        end else begin
          buffer_write_enable_out  <= 1'b1;
          buffer_write_address_out <= words_written[ADDR_WIDTH-1:0];
          buffer_write_data_out    <= pixel_word_in;
          words_written            <= words_written + CW'(1);
        end
      end
    end
  end

  assign bytes_written = words_written << BYTE_SHIFT;
  assign avail         = bytes_written - bytes_read;
  assign avail_ext     = AW'(avail);
  assign read_edge     = cmd_read && operand_valid_in && !operand_prev;

  // When the reader has caught up with the writer, keep pointing at the last
  // byte handed out so repeated reads return it again.
  always_comb begin
    read_ptr = bytes_read;
    if ((bytes_read >= bytes_written) && (bytes_read != '0))
      read_ptr = bytes_read - CW'(1);
  end

  always_ff @(posedge clock_spi_in or negedge reset_sync_n) begin
    if (!reset_sync_n) begin
      bytes_read              <= '0;
      operand_prev            <= 1'b0;
      snapshot                <= '0;
      buffer_read_address_out <= '0;
    end else begin
      operand_prev            <= operand_valid_in;
      buffer_read_address_out <= ADDR_WIDTH'(read_ptr >> BYTE_SHIFT);
      if (arming)
        bytes_read <= '0;
      else if (read_edge && (bytes_read < bytes_written))
        bytes_read <= bytes_read + CW'(1);
      if (cmd_avail && (operand_count_in == '0))
        snapshot <= avail_ext;
    end
  end

  always_comb begin
    avail_byte = 8'h00;
    if (operand_count_in < 32'(COUNT_BYTES))
      avail_byte = 8'(((operand_count_in == '0) ? avail_ext : snapshot)
                      >> (8 * (COUNT_BYTES - 1 - int'(operand_count_in))));
    read_byte = 8'(buffer_read_data_in >> (8 * (BYTES - 1 - int'(read_ptr & BYTE_MASK))));
    response_next = 8'h00;
    if (cmd_avail)       response_next = avail_byte;
    else if (cmd_read)   response_next = read_byte;
    else if (cmd_status) response_next = {4'b0000, overflow, state == ST_DONE,
                                          state == ST_CAPTURING, state == ST_ARMED};
  end

  always_ff @(posedge clock_spi_in or negedge reset_sync_n) begin
    if (!reset_sync_n) begin
      response_out       <= 8'h00;
      response_valid_out <= 1'b0;
    end else begin
      response_out       <= response_next;
      response_valid_out <= cmd_avail || cmd_read || cmd_status;
    end
  end

endmodule

// File: tb/tb_frame_buffer_controller.sv
// Randomised self-checking bench: a behavioural model of the capture buffer
// predicts writes, byte counts, read bytes and status for frame_buffer_controller.
module tb_frame_buffer_controller;

  logic        clock = 1'b0;
  logic        reset_sync_n = 1'b1;
  logic [7:0]  op_code_in = 8'h00;
  logic        op_code_valid_in = 1'b0;
  logic [7:0]  operand_in = 8'h00;
  logic        operand_valid_in = 1'b0;
  logic [31:0] operand_count_in = 32'd0;
  logic [7:0]  response_out;
  logic        response_valid_out;
  logic [31:0] pixel_word_in = 32'd0;
  logic        pixel_word_valid_in = 1'b0;
  logic        frame_valid_in = 1'b0;
  logic        buffer_write_enable_out;
  logic [3:0]  buffer_write_address_out;
  logic [31:0] buffer_write_data_out;
  logic [3:0]  buffer_read_address_out;
  logic [31:0] buffer_read_data_in;
  logic        capture_active_out;

  frame_buffer_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .COUNT_BYTES(3)) dut (
    .clock_spi_in             (clock),
    .reset_sync_n             (reset_sync_n),
    .op_code_in               (op_code_in),
    .op_code_valid_in         (op_code_valid_in),
    .operand_in               (operand_in),
    .operand_valid_in         (operand_valid_in),
    .operand_count_in         (operand_count_in),
    .response_out             (response_out),
    .response_valid_out       (response_valid_out),
    .pixel_word_in            (pixel_word_in),
    .pixel_word_valid_in      (pixel_word_valid_in),
    .frame_valid_in           (frame_valid_in),
    .buffer_write_enable_out  (buffer_write_enable_out),
    .buffer_write_address_out (buffer_write_address_out),
    .buffer_write_data_out    (buffer_write_data_out),
    .buffer_read_address_out  (buffer_read_address_out),
    .buffer_read_data_in      (buffer_read_data_in),
    .capture_active_out       (capture_active_out)
  );

  always #5 clock = ~clock;

  // External RAM with one-cycle read latency; also counts committed writes.
  logic [31:0] ram [16];
  logic [31:0] ram_q = 32'd0;
  int write_count = 0;
  always @(posedge clock) begin
    if (buffer_write_enable_out) begin
      ram[buffer_write_address_out] <= buffer_write_data_out;
      write_count <= write_count + 1;
    end
    ram_q <= ram[buffer_read_address_out];
  end
  assign buffer_read_data_in = ram_q;

  // Reference model: 0 idle, 1 armed, 2 capturing, 3 done.
  logic [31:0] model_mem [16];
  int model_state = 0;
  int model_words = 0;
  int model_read = 0;
  int model_writes = 0;
  bit model_overflow = 1'b0;

  int check_count = 0;
  int pass_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] model_status();
    return {4'b0000, model_overflow, model_state == 3, model_state == 2, model_state == 1};
  endfunction

  function automatic logic [7:0] model_byte();
    int pos;
    logic [31:0] word;
    // Nothing new to hand out: the last consumed byte is repeated.
    pos = (model_read < model_words * 4) ? model_read : model_read - 1;
    word = model_mem[pos / 4];
    return 8'(word >> (8 * (3 - pos % 4)));
  endfunction

  task automatic send_cmd(input logic [7:0] op);
    op_code_in = op;
    op_code_valid_in = 1'b1;
    tick(1);
    op_code_valid_in = 1'b0;
    if (op == 8'h20 && (model_state == 0 || model_state == 3)) begin
      model_state = 1;
      model_words = 0;
      model_read = 0;
      model_overflow = 1'b0;
    end
    if (op == 8'h25) model_state = 0;
    checkOutput($sformatf("no_resp_%0h", op), {31'd0, response_valid_out}, 32'd0);
    tick(1);
  endtask

  task automatic check_status(input string tag);
    op_code_in = 8'h24;
    op_code_valid_in = 1'b1;
    tick(1);
    checkOutput({tag, "_valid"}, {31'd0, response_valid_out}, 32'd1);
    checkOutput(tag, {24'd0, response_out}, {24'd0, model_status()});
    op_code_valid_in = 1'b0;
    tick(1);
  endtask

  task automatic check_avail(input string tag);
    logic [23:0] expected;
    expected = 24'(model_words * 4 - model_read);
    op_code_in = 8'h21;
    op_code_valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      operand_count_in = k;
      tick(1);
      checkOutput($sformatf("%s_b%0d", tag, k), {24'd0, response_out},
                  (k < 3) ? {24'd0, 8'(expected >> (8 * (2 - k)))} : 32'd0);
    end
    op_code_valid_in = 1'b0;
    operand_count_in = 0;
    tick(1);
  endtask

  task automatic read_bytes(input int n, input string tag);
    op_code_in = 8'h22;
    op_code_valid_in = 1'b1;
    operand_count_in = 0;
    for (int i = 0; i < n; i++) begin
      tick(4);
      checkOutput($sformatf("%s_rd%0d", tag, i), {24'd0, response_out}, {24'd0, model_byte()});
      operand_valid_in = 1'b1;
      tick(1);
      operand_valid_in = 1'b0;
      if (model_read < model_words * 4) model_read++;
    end
    op_code_valid_in = 1'b0;
    tick(1);
  endtask

  task automatic frame_start();
    frame_valid_in = 1'b1;
    tick(5);
    if (model_state == 1) model_state = 2;
  endtask

  task automatic frame_end();
    frame_valid_in = 1'b0;
    tick(5);
    if (model_state == 2) model_state = 3;
  endtask

  task automatic push_word(input logic [31:0] word);
    pixel_word_in = word;
    pixel_word_valid_in = 1'b1;
    tick(1);
    pixel_word_valid_in = 1'b0;
    if (model_state == 2) begin
      if (model_words < 16) begin
        model_mem[model_words] = word;
        model_words++;
        model_writes++;
      end else begin
        model_overflow = 1'b1;
      end
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] basic_words [5];
    basic_words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h12345678};

    #1 reset_sync_n = 1'b0;
    #2;
    checkOutput("rst_wr_en", {31'd0, buffer_write_enable_out}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, response_valid_out}, 32'd0);
    checkOutput("rst_capture", {31'd0, capture_active_out}, 32'd0);
    checkOutput("rst_rd_addr", {28'd0, buffer_read_address_out}, 32'd0);
    tick(3);
    reset_sync_n = 1'b1;
    tick(2);
    check_status("rst_status");

    // Basic capture and in-order readout.
    send_cmd(8'h20);
    check_status("basic_armed");
    frame_start();
    for (int i = 0; i < 5; i++) push_word(basic_words[i]);
    frame_end();
    checkOutput("basic_writes", write_count, model_writes);
    check_status("basic_done");
    check_avail("basic_avail");
    read_bytes(20, "basic");
    check_avail("basic_avail_end");

    // Overflow: only the first sixteen words land.
    send_cmd(8'h20);
    frame_start();
    for (int i = 0; i < 20; i++) push_word($urandom);
    frame_end();
    checkOutput("ovf_writes", write_count, model_writes);
    check_status("ovf_status");
    check_avail("ovf_avail");
    read_bytes(6, "ovf");

    // Streaming readout while still capturing.
    send_cmd(8'h20);
    frame_start();
    for (int i = 0; i < 8; i++) push_word($urandom);
    check_status("stream_status");
    check_avail("stream_avail0");
    read_bytes(4, "stream");
    check_avail("stream_avail1");
    push_word($urandom);
    frame_end();
    check_status("stream_done");
    check_avail("stream_avail2");

    // Underread: reader stops at the written byte count.
    send_cmd(8'h20);
    frame_start();
    push_word($urandom);
    frame_end();
    read_bytes(6, "under");
    check_avail("under_avail");

    // Abort with a word arriving in the same cycle.
    send_cmd(8'h20);
    frame_start();
    for (int i = 0; i < 3; i++) push_word($urandom);
    pixel_word_in = $urandom;
    pixel_word_valid_in = 1'b1;
    op_code_in = 8'h25;
    op_code_valid_in = 1'b1;
    tick(1);
    op_code_valid_in = 1'b0;
    pixel_word_valid_in = 1'b0;
    model_state = 0;
    checkOutput("abort_wr_en", {31'd0, buffer_write_enable_out}, 32'd0);
    tick(1);
    push_word($urandom);
    checkOutput("abort_writes", write_count, model_writes);
    check_status("abort_status");
    frame_end();
    send_cmd(8'h20);
    check_status("rearm_status");
    frame_start();
    push_word($urandom);
    frame_end();
    read_bytes(4, "rearm");

    // Randomised frames with gaps, then partial reads.
    for (int r = 0; r < 5; r++) begin
      int n;
      send_cmd(8'h20);
      frame_start();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) != 0) push_word($urandom);
        else tick(1);
      end
      frame_end();
      checkOutput($sformatf("rand%0d_writes", r), write_count, model_writes);
      check_status($sformatf("rand%0d_status", r));
      if (model_words > 0) read_bytes($urandom_range(1, 10), $sformatf("rand%0d", r));
      check_avail($sformatf("rand%0d_avail", r));
    end

    // Asynchronous reset in the middle of a capture.
    send_cmd(8'h20);
    frame_start();
    push_word($urandom);
    pixel_word_in = $urandom;
    pixel_word_valid_in = 1'b1;
    tick(1);
    checkOutput("pre_rst_wr_en", {31'd0, buffer_write_enable_out}, 32'd1);
    op_code_in = 8'h24;
    op_code_valid_in = 1'b1;
    #2 reset_sync_n = 1'b0;
    #1;
    checkOutput("midrst_wr_en", {31'd0, buffer_write_enable_out}, 32'd0);
    checkOutput("midrst_capture", {31'd0, capture_active_out}, 32'd0);
    checkOutput("midrst_wr_addr", {28'd0, buffer_write_address_out}, 32'd0);
    checkOutput("midrst_wr_data", buffer_write_data_out, 32'd0);
    checkOutput("midrst_resp", {23'd0, response_valid_out, response_out}, 32'd0);
    op_code_valid_in = 1'b0;
    pixel_word_valid_in = 1'b0;
    frame_valid_in = 1'b0;
    tick(2);
    reset_sync_n = 1'b1;
    model_state = 0;
    model_words = 0;
    model_read = 0;
    model_overflow = 1'b0;
    tick(2);
    check_status("postrst_status");
    check_avail("postrst_avail");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
